// File: rtl/msgbuf_pkg.sv
// Shared defaults, load/pending state type and reset pattern for message_buffer.
package msgbuf_pkg;

    localparam int CHAR_W_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic {
        LOADING = 1'b0,
        PENDING = 1'b1
    } buf_state_e;

    // Reset pattern: entry i holds its own index, truncated by the caller to the character width.
    function automatic logic [31:0] reset_char(input int idx);
        return 32'(idx);
    endfunction

endpackage

// File: rtl/msgbuf_bank.sv
// One DEPTH x CHAR_W character bank: synchronous write, asynchronous read,
// asynchronous reset to the identity pattern.
module msgbuf_bank
    import msgbuf_pkg::*;
#(
    parameter int CHAR_W = CHAR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= CHAR_W'(reset_char(i));
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/message_buffer.sv
// Scrolling-display message buffer; define MSGBUF_DOUBLE_BUFFER_EN for a
// shadow bank swapped on swap_req, otherwise writes land in the displayed bank.
module message_buffer
    import msgbuf_pkg::*;
#(
    parameter int CHAR_W = CHAR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [CHAR_W-1:0]        wr_char,
    output logic                     wr_ready,
    input  logic                     wr_abort,
    input  logic                     swap_req,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [CHAR_W-1:0]        rd_char,
    output logic                     frame_pending,
    output logic                     frame_done,
    output logic                     state_dbg
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    buf_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          active_q, active_d;
    logic          frame_done_q, frame_done_d;
    logic          armed_q;
    logic          accept;
    logic          wrap;
    logic          swap;

    // Write handshake: a character moves when wr_valid && wr_ready on a rising
    // edge; wr_abort in the same cycle discards it.
    assign wr_ready      = armed_q && (state_q == LOADING);
    assign accept        = wr_valid && wr_ready && !wr_abort;
    assign wrap          = accept && (wr_ptr_q == LAST);
    assign frame_pending = (state_q == PENDING);
    assign frame_done    = frame_done_q;
    assign state_dbg     = state_q;

`ifdef MSGBUF_DOUBLE_BUFFER_EN
    assign swap = (state_q == PENDING) && swap_req && !wr_abort;
`else
    logic unused_swap_req;
    logic unused_active;
    assign unused_swap_req = swap_req;
    assign unused_active   = active_q;
    assign swap            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOADING;
            wr_ptr_q     <= '0;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
            armed_q      <= 1'b1;
        end
    end

    // Abort dominates; wrap can only happen while LOADING and swap only while
    // PENDING, so a wrap write never swaps on its own edge.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        active_d     = active_q;
        frame_done_d = 1'b0;
        if (wr_abort) begin
            state_d  = LOADING;
            wr_ptr_d = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wrap) begin
`ifdef MSGBUF_DOUBLE_BUFFER_EN
                state_d = PENDING;
`else
                frame_done_d = 1'b1;
`endif
            end
        end else if (swap) begin
            state_d      = LOADING;
            active_d     = ~active_q;
            frame_done_d = 1'b1;
        end
    end

`ifdef MSGBUF_DOUBLE_BUFFER_EN
    logic [CHAR_W-1:0] rd_data0, rd_data1;

    // The shadow bank is always the one not selected by active_q.
    msgbuf_bank #(.CHAR_W(CHAR_W), .DEPTH(DEPTH)) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept && active_q),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_char),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    msgbuf_bank #(.CHAR_W(CHAR_W), .DEPTH(DEPTH)) u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept && !active_q),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_char),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    assign rd_char = active_q ? rd_data1 : rd_data0;
`else
    msgbuf_bank #(.CHAR_W(CHAR_W), .DEPTH(DEPTH)) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_char),
        .rd_addr (rd_addr),
        .rd_data (rd_char)
    );
`endif

endmodule

// File: tb/tb_message_buffer.sv
// Directed bench for message_buffer; covers the build selected by MSGBUF_DOUBLE_BUFFER_EN.
module tb_message_buffer;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic [3:0] wr_char;
    logic       wr_ready;
    logic       wr_abort;
    logic       swap_req;
    logic [3:0] rd_addr;
    logic [3:0] rd_char;
    logic       frame_pending;
    logic       frame_done;
    logic       state_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] PAT_IDENTITY = 64'hFEDCBA9876543210;

    message_buffer #(.CHAR_W(4), .DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_char       (wr_char),
        .wr_ready      (wr_ready),
        .wr_abort      (wr_abort),
        .swap_req      (swap_req),
        .rd_addr       (rd_addr),
        .rd_char       (rd_char),
        .frame_pending (frame_pending),
        .frame_done    (frame_done),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_char(input logic [3:0] c);
        wr_valid = 1'b1;
        wr_char  = c;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [3:0] addr, input logic [3:0] exp);
        rd_addr = addr;
        #1;
        check(tag, rd_char, exp);
        tick();
    endtask

    task automatic sweep(input string tag, input logic [63:0] pattern);
        for (int i = 0; i < 16; i++) begin
            peek(tag, 4'(i), pattern[i*4 +: 4]);
        end
    endtask

    initial begin
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_char  = '0;
        wr_abort = 1'b0;
        swap_req = 1'b0;
        rd_addr  = '0;
        tick();

        // Reset state and identity pattern, then wr_ready one cycle after release.
        check("rst_wr_ready", wr_ready, 0);
        check("rst_pending", frame_pending, 0);
        check("rst_done", frame_done, 0);
        sweep("rst_identity", PAT_IDENTITY);
        reset = 1'b1;
        #1;
        check("release_wr_ready_low", wr_ready, 0);
        tick();
        check("release_wr_ready_high", wr_ready, 1);

`ifdef MSGBUF_DOUBLE_BUFFER_EN
        // Full frame F..0, no swap yet.
        for (int i = 0; i < 16; i++) write_char(4'(15 - i));
        check("full_pending", frame_pending, 1);
        check("full_wr_ready", wr_ready, 0);
        check("full_state", state_dbg, 1);
        check("full_done", frame_done, 0);
        wr_valid = 1'b1;
        wr_char  = 4'h5;
        tick();
        wr_valid = 1'b0;
        check("pending_write_ignored", frame_pending, 1);
        sweep("old_bank_visible", PAT_IDENTITY);
        rd_addr  = 4'h0;
        swap_req = 1'b1;
        #1;
        check("pre_swap_char", rd_char, 4'h0);
        tick();
        swap_req = 1'b0;
        check("swap_done", frame_done, 1);
        check("swap_pending", frame_pending, 0);
        check("swap_wr_ready", wr_ready, 1);
        check("swap_addr0", rd_char, 4'hF);
        tick();
        check("swap_done_pulse_end", frame_done, 0);
        sweep("new_frame_rev", 64'h0123456789ABCDEF);

        // Swap request on the wrap edge is not honoured until the next request.
        for (int i = 0; i < 15; i++) write_char(4'((i * 3) & 15));
        wr_valid = 1'b1;
        wr_char  = 4'hD;
        swap_req = 1'b1;
        tick();
        wr_valid = 1'b0;
        swap_req = 1'b0;
        check("same_edge_pending", frame_pending, 1);
        check("same_edge_done", frame_done, 0);
        peek("same_edge_old_bank", 4'h0, 4'hF);
        check("same_edge_still_pending", frame_pending, 1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("late_swap_done", frame_done, 1);
        tick();
        sweep("late_swap_frame", 64'hDA741EB852FC9630);

        // Swap request with nothing pending.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("idle_swap_done", frame_done, 0);
        check("idle_swap_pending", frame_pending, 0);
        peek("idle_swap_bank", 4'h1, 4'h3);

        // Abort after seven writes; abort beats the write offered with it.
        for (int i = 0; i < 7; i++) write_char(4'hA);
        wr_abort = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 4'h1;
        tick();
        wr_abort = 1'b0;
        wr_valid = 1'b0;
        check("abort_pending", frame_pending, 0);
        check("abort_wr_ready", wr_ready, 1);
        for (int i = 0; i < 15; i++) write_char(4'((i + 7) & 15));
        check("abort_ptr_reset", frame_pending, 0);
        write_char(4'h6);
        check("abort_refill_pending", frame_pending, 1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("abort_refill_done", frame_done, 1);
        tick();
        sweep("abort_refill_frame", 64'h6543210FEDCBA987);

        // Abort together with a valid swap: no swap, no frame_done.
        for (int i = 0; i < 16; i++) write_char(4'hC);
        check("abort_swap_pre_pending", frame_pending, 1);
        wr_abort = 1'b1;
        swap_req = 1'b1;
        tick();
        wr_abort = 1'b0;
        swap_req = 1'b0;
        check("abort_swap_done", frame_done, 0);
        check("abort_swap_pending", frame_pending, 0);
        check("abort_swap_wr_ready", wr_ready, 1);
        peek("abort_swap_bank", 4'h0, 4'h7);
        check("abort_swap_done_after", frame_done, 0);

        // Asynchronous reset mid-frame and while pending.
        for (int i = 0; i < 5; i++) write_char(4'h2);
        reset = 1'b0;
        #1;
        check("rst_mid_wr_ready", wr_ready, 0);
        check("rst_mid_pending", frame_pending, 0);
        check("rst_mid_state", state_dbg, 0);
        peek("rst_mid_identity", 4'h5, 4'h5);
        reset = 1'b1;
        tick();
        check("rst_mid_release_ready", wr_ready, 1);
        for (int i = 0; i < 16; i++) write_char(4'h9);
        check("rst_pend_pre_pending", frame_pending, 1);
        reset = 1'b0;
        #1;
        check("rst_pend_pending", frame_pending, 0);
        check("rst_pend_wr_ready", wr_ready, 0);
        peek("rst_pend_identity", 4'h9, 4'h9);
        reset = 1'b1;
        tick();
        sweep("rst_pend_sweep", PAT_IDENTITY);
`else
        // Single bank: writes are displayed directly.
        rd_addr  = 4'h0;
        wr_valid = 1'b1;
        wr_char  = 4'hA;
        #1;
        check("single_pre_write", rd_char, 4'h0);
        tick();
        wr_valid = 1'b0;
        check("single_write_a", rd_char, 4'hA);
        check("single_pending", frame_pending, 0);
        check("single_done_early", frame_done, 0);
        check("single_wr_ready", wr_ready, 1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("single_swap_char", rd_char, 4'hA);
        check("single_swap_done", frame_done, 0);
        check("single_swap_pending", frame_pending, 0);
        check("single_swap_ready", wr_ready, 1);
        check("single_state", state_dbg, 0);

        for (int i = 1; i < 15; i++) write_char(4'(15 - i));
        check("single_pre_wrap_done", frame_done, 0);
        write_char(4'h0);
        check("single_wrap_done", frame_done, 1);
        check("single_wrap_pending", frame_pending, 0);
        check("single_wrap_ready", wr_ready, 1);
        tick();
        check("single_wrap_done_end", frame_done, 0);
        sweep("single_frame", 64'h0123456789ABCDEA);

        // Abort with a concurrent write: pointer returns to 0, write dropped.
        write_char(4'h1);
        write_char(4'h2);
        write_char(4'h3);
        wr_abort = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 4'hE;
        tick();
        wr_abort = 1'b0;
        wr_valid = 1'b0;
        write_char(4'h9);
        peek("single_abort_addr0", 4'h0, 4'h9);
        peek("single_abort_addr1", 4'h1, 4'h2);
        peek("single_abort_addr2", 4'h2, 4'h3);
        peek("single_abort_dropped", 4'h3, 4'hC);

        // Asynchronous reset mid-frame.
        write_char(4'h4);
        reset = 1'b0;
        #1;
        check("single_rst_wr_ready", wr_ready, 0);
        check("single_rst_done", frame_done, 0);
        peek("single_rst_identity", 4'h1, 4'h1);
        reset = 1'b1;
        tick();
        check("single_rst_release_ready", wr_ready, 1);
        sweep("single_rst_sweep", PAT_IDENTITY);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
